// File: rtl/mem_arb_ctrl_if.sv
// Bus bundle for mem_arb_ctrl: requester channels on one side, the byte-wide memory port on the other.
// The arbiter attaches through the slave modport; a requester/memory model attaches through master.
interface mem_arb_ctrl_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32
);
  logic                        rdy;
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        rw;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*32-1:0]     wdata;
  logic [NUM_PORTS*2-1:0]      len;
  logic [31:0]                 rdata;
  logic [NUM_PORTS-1:0]        done;
  logic [NUM_PORTS-1:0]        stall;
  logic [ADDR_W-1:0]           mem_a;
  logic [7:0]                  mem_dout;
  logic                        mem_wr;
  logic [7:0]                  mem_din;

  modport slave (
    input  rdy, req, rw, addr, wdata, len, mem_din,
    output rdata, done, stall, mem_a, mem_dout, mem_wr
  );

  modport master (
    output rdy, req, rw, addr, wdata, len, mem_din,
    input  rdata, done, stall, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Arbitrates NUM_PORTS requesters onto a byte-wide memory, splitting each 1/2/4-byte
// transfer into byte accesses and assembling little-endian read words.
module mem_arb_ctrl #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int RR_MODE   = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arb_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, ISSUE, LAST, DONE} state_t;

  state_t               r_state;
  logic [1:0]           r_k;
  logic [1:0]           r_lastK;
  logic [IDX_W-1:0]     r_grant;
  logic [IDX_W-1:0]     r_rrPtr;
  logic                 r_rw;
  logic [ADDR_W-1:0]    r_start;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdBuf;
  logic [31:0]          r_rdata;
  logic [ADDR_W-1:0]    r_memA;
  logic [7:0]           r_memDout;
  logic                 r_memWr;
  logic [NUM_PORTS-1:0] r_done;

  logic                 w_anyReq;
  logic [IDX_W-1:0]     w_grant;
  logic [ADDR_W-1:0]    w_addrSel;
  logic [31:0]          w_wdataSel;
  logic [1:0]           w_lenSel;
  logic [1:0]           w_lastKSel;
  logic [1:0]           w_kNext;
  logic [1:0]           w_kPrev;
  logic [31:0]          w_rdFinal;

  // Walk candidates from the highest search offset down so the nearest requester wins.
  always_comb begin
    int pick;
    w_anyReq = 1'b0;
    w_grant  = '0;
    pick     = 0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (RR_MODE != 0) begin
        pick = int'(r_rrPtr) + j;
        if (pick >= NUM_PORTS) pick = pick - NUM_PORTS;
      end else begin
        pick = j;
      end
      if (bus.req[pick]) begin
        w_anyReq = 1'b1;
        w_grant  = IDX_W'(pick);
      end
    end
  end

  assign w_addrSel  = bus.addr[w_grant*ADDR_W +: ADDR_W];
  assign w_wdataSel = bus.wdata[w_grant*32 +: 32];
  assign w_lenSel   = bus.len[w_grant*2 +: 2];
  assign w_lastKSel = (w_lenSel == 2'b00) ? 2'd0 : (w_lenSel == 2'b01) ? 2'd1 : 2'd3;
  assign w_kNext    = r_k + 2'd1;
  assign w_kPrev    = r_k - 2'd1;

  // Bytes above the transfer length were cleared at grant, so the word is already zero-extended.
  always_comb begin
    w_rdFinal                  = r_rdBuf;
    w_rdFinal[8*r_lastK +: 8]  = bus.mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_lastK   <= '0;
      r_grant   <= '0;
      r_rrPtr   <= '0;
      r_rw      <= 1'b0;
      r_start   <= '0;
      r_wdata   <= '0;
      r_rdBuf   <= '0;
      r_rdata   <= '0;
      r_memA    <= '0;
      r_memDout <= '0;
      r_memWr   <= 1'b0;
      r_done    <= '0;
    end else if (bus.rdy) begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_grant   <= w_grant;
            r_rw      <= bus.rw[w_grant];
            r_start   <= w_addrSel;
            r_wdata   <= w_wdataSel;
            r_lastK   <= w_lastKSel;
            r_k       <= '0;
            r_rdBuf   <= '0;
            r_memA    <= w_addrSel;
            r_memDout <= w_wdataSel[7:0];
            r_memWr   <= bus.rw[w_grant];
            if (RR_MODE != 0) begin
              r_rrPtr <= (w_grant == IDX_W'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;
            end
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Memory data trails its address by one cycle, so this cycle returns byte k-1.
          if (!r_rw && r_k != 2'd0) begin
            r_rdBuf[8*w_kPrev +: 8] <= bus.mem_din;
          end
          if (r_k == r_lastK) begin
            r_memWr <= 1'b0;
            if (r_rw) begin
              r_done[r_grant] <= 1'b1;
              r_state         <= DONE;
            end else begin
              r_state <= LAST;
            end
          end else begin
            r_k       <= w_kNext;
            r_memA    <= r_start + ADDR_W'(w_kNext);
            r_memDout <= r_wdata[8*w_kNext +: 8];
          end
        end
        LAST: begin
          r_rdata         <= w_rdFinal;
          r_done[r_grant] <= 1'b1;
          r_state         <= DONE;
        end
        DONE: begin
          r_done  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gating with rdy keeps a frozen cycle from issuing a write or showing a second done pulse.
  assign bus.rdata    = r_rdata;
  assign bus.mem_a    = r_memA;
  assign bus.mem_dout = r_memDout;
  assign bus.mem_wr   = r_memWr & bus.rdy;
  assign bus.done     = r_done & {NUM_PORTS{bus.rdy}};
  assign bus.stall    = bus.req & ~bus.done;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Randomized scoreboard bench for mem_arb_ctrl: a byte-level reference memory predicts grants,
// latencies and read words; a separate monitor compares them as done pulses appear.
module tb_mem_arb_ctrl;

  localparam int NP = 3;
  localparam int AW = 32;

  typedef struct {
    int          port;
    bit          isWrite;
    logic [31:0] addr;
    int          nBytes;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          doneAt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_ctrl_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();
  mem_arb_ctrl #(.NUM_PORTS(NP), .ADDR_W(AW), .RR_MODE(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  mem_arb_ctrl_if #(.NUM_PORTS(2), .ADDR_W(16)) bus2 ();
  mem_arb_ctrl #(.NUM_PORTS(2), .ADDR_W(16), .RR_MODE(0)) dutFixed (.clk(clk), .rst(rst), .bus(bus2));

  int compared   = 0;
  int mismatched = 0;
  int activeCnt  = 0;
  int fixedDones = 0;
  bit rdyRandom  = 1'b0;

  logic [7:0]    busMem [logic [31:0]];
  logic [7:0]    refMem [logic [31:0]];
  exp_t          expQ[$];
  int            mPtr     = 0;
  logic [31:0]   lastRead = 32'h0;

  logic [NP-1:0] tbReq;
  logic          opRw   [NP];
  logic [31:0]   opAddr [NP];
  logic [31:0]   opData [NP];
  logic [1:0]    opLen  [NP];

  function automatic logic [7:0] initByte(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rdBus(logic [31:0] a);
    return busMem.exists(a) ? busMem[a] : initByte(a);
  endfunction

  function automatic logic [7:0] rdRef(logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initByte(a);
  endfunction

  function automatic int lenBytes(logic [1:0] l);
    return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
  endfunction

  task automatic finishRun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic driveBus();
    for (int p = 0; p < NP; p++) begin
      bus.req[p]             = tbReq[p];
      bus.rw[p]              = opRw[p];
      bus.addr[p*AW +: AW]   = opAddr[p];
      bus.wdata[p*32 +: 32]  = opData[p];
      bus.len[p*2 +: 2]      = opLen[p];
    end
  endtask

  task automatic setRequest(input int p, input bit w, input logic [31:0] a, input logic [1:0] l,
                            input logic [31:0] d);
    opRw[p]   = w;
    opAddr[p] = a;
    opLen[p]  = l;
    opData[p] = d;
    tbReq[p]  = 1'b1;
  endtask

  // Addresses cluster in a small window and at the top of memory so reads hit earlier writes and wrap.
  task automatic randomRequest(input int p);
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    else                           a = 32'h0000_0100 + 32'($urandom_range(0, 15));
    setRequest(p, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom);
  endtask

  // Predicts the next grant and its response, waits for the transfer, then updates requests
  // in the idle cycle that follows the done pulse.
  task automatic applyStimulus(input bit refill);
    exp_t e;
    int   g;
    int   waited;
    logic [31:0] rd;
    g = -1;
    for (int j = 0; j < NP; j++) begin
      int idx = (mPtr + j) % NP;
      if (g < 0 && tbReq[idx]) g = idx;
    end
    if (g < 0) return;
    e.port    = g;
    e.isWrite = opRw[g];
    e.addr    = opAddr[g];
    e.nBytes  = lenBytes(opLen[g]);
    e.wdata   = opData[g];
    e.doneAt  = activeCnt + 1 + e.nBytes + (e.isWrite ? 0 : 1);
    if (e.isWrite) begin
      for (int i = 0; i < e.nBytes; i++) refMem[e.addr + 32'(i)] = e.wdata[8*i +: 8];
      e.rdata = lastRead;
    end else begin
      rd = 32'h0;
      for (int i = 0; i < e.nBytes; i++) rd[8*i +: 8] = rdRef(e.addr + 32'(i));
      e.rdata  = rd;
      lastRead = rd;
    end
    expQ.push_back(e);
    mPtr = (g + 1) % NP;

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.done == '0 && waited < 200);
    if (bus.done == '0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_timeout: port %0d saw no done in %0d cycles, required one", g, waited);
      finishRun();
    end

    @(posedge clk);
    #1;
    if (refill) begin
      if ($urandom_range(0, 9) < 7) randomRequest(g);
      else                          tbReq[g] = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (!tbReq[p] && $urandom_range(0, 1) == 1) randomRequest(p);
      end
      if (tbReq == '0) randomRequest(int'($urandom_range(0, NP - 1)));
    end else begin
      tbReq[g] = 1'b0;
    end
    driveBus();
  endtask

  // Counts only clock edges on which the arbiter is allowed to advance.
  always @(posedge clk) begin
    if (!rst && bus.rdy) activeCnt++;
  end

  initial begin
    bus.rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rdy = rdyRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Byte memory: returns data one enabled cycle after the address and freezes while rdy is low.
  initial begin
    logic [31:0] pA;
    logic [7:0]  pD;
    logic        pRdy;
    logic        pWr;
    bus.mem_din = 8'h00;
    forever begin
      @(negedge clk);
      pA   = bus.mem_a;
      pD   = bus.mem_dout;
      pRdy = bus.rdy;
      pWr  = bus.mem_wr;
      @(posedge clk);
      #1;
      if (pRdy) begin
        if (pWr) busMem[pA] = pD;
        bus.mem_din = rdBus(pA);
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic [NP-1:0] expDone;
    logic [31:0] word;
    logic [31:0] mask;
    forever begin
      @(negedge clk);
      if (!rst) begin
        expDone = '0;
        if (bus.done != '0) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 64'(bus.done), 64'(0));
          end else begin
            e = expQ.pop_front();
            expDone[e.port] = 1'b1;
            checkOutput("done_port", 64'(bus.done), 64'(expDone));
            checkOutput("done_cycle", 64'(activeCnt), 64'(e.doneAt));
            checkOutput(e.isWrite ? "rdata_hold" : "rdata_read", 64'(bus.rdata), 64'(e.rdata));
            if (e.isWrite) begin
              word = 32'h0;
              for (int i = 0; i < e.nBytes; i++) word[8*i +: 8] = rdBus(e.addr + 32'(i));
              mask = (e.nBytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * e.nBytes)) - 32'h1);
              checkOutput("mem_written", 64'(word), 64'(e.wdata & mask));
            end
          end
        end
        checkOutput("stall", 64'(bus.stall), 64'(bus.req & ~expDone));
        if (!bus.rdy) checkOutput("mem_wr_gated", 64'(bus.mem_wr), 64'(0));
      end
    end
  end

  initial begin : fixedMonitor
    forever begin
      @(negedge clk);
      if (!rst && bus2.done != '0) begin
        fixedDones++;
        checkOutput("fixed_grant", 64'(bus2.done), 64'(2'b01));
        checkOutput("fixed_rdata", 64'(bus2.rdata), 64'(32'h0000_005C));
        checkOutput("fixed_stall1", 64'(bus2.stall[1]), 64'(1));
      end
    end
  end

  initial begin
    #500000;
    compared++;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    finishRun();
  end

  initial begin
    rst   = 1'b1;
    tbReq = '0;
    for (int p = 0; p < NP; p++) setRequest(p, 1'b0, 32'h0, 2'b00, 32'h0);
    tbReq = '0;
    driveBus();
    bus2.req   = 2'b11;
    bus2.rw    = 2'b00;
    bus2.addr  = {16'h0040, 16'h0020};
    bus2.wdata = '0;
    bus2.len   = 4'b0000;
    bus2.rdy   = 1'b1;
    bus2.mem_din = 8'h5C;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_done", 64'(bus.done), 64'(0));
    checkOutput("rst_mem_wr", 64'(bus.mem_wr), 64'(0));
    checkOutput("rst_rdata", 64'(bus.rdata), 64'(0));
    checkOutput("rst_mem_a", 64'(bus.mem_a), 64'(0));
    checkOutput("rst_mem_dout", 64'(bus.mem_dout), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed write, read-back and top-of-memory wrap");
    setRequest(0, 1'b1, 32'h0000_0100, 2'b10, 32'h4433_2211);
    setRequest(1, 1'b0, 32'h0000_0100, 2'b01, 32'h0);
    setRequest(2, 1'b1, 32'hFFFF_FFFE, 2'b10, 32'hA5A5_5A5A);
    driveBus();
    repeat (3) applyStimulus(1'b0);

    $display("[TB] randomized traffic with rdy gating");
    rdyRandom = 1'b1;
    for (int p = 0; p < NP; p++) randomRequest(p);
    driveBus();
    repeat (150) applyStimulus(1'b1);

    $display("[TB] reset during a write");
    rdyRandom = 1'b0;
    tbReq = '0;
    driveBus();
    @(posedge clk);
    #2;
    setRequest(0, 1'b1, 32'h0000_8000, 2'b10, 32'hDEAD_BEEF);
    setRequest(1, 1'b0, 32'h0000_8000, 2'b10, 32'h0);
    driveBus();
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b1;
    tbReq = '0;
    driveBus();
    @(posedge clk);
    #1;
    checkOutput("rst_mid_mem_wr", 64'(bus.mem_wr), 64'(0));
    checkOutput("rst_mid_done", 64'(bus.done), 64'(0));
    rst      = 1'b0;
    mPtr     = 0;
    lastRead = 32'h0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_after_rst", 64'(bus.mem_wr), 64'(0));
    end
    @(posedge clk);
    #1;
    randomRequest(0);
    randomRequest(1);
    driveBus();
    repeat (2) applyStimulus(1'b0);

    repeat (5) @(posedge clk);
    checkOutput("fixed_done_count_ok", 64'(fixedDones >= 5), 64'(1));
    finishRun();
  end

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requester channels, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rdy  input  1  global enable; low freezes the block.
REQ-007 SHALL have port req  input  NUM_PORTS  per-port transfer request.
REQ-008 SHALL have port rw  input  NUM_PORTS  per-port direction, 1 = write, 0 = read.
REQ-009 SHALL have port addr  input  NUM_PORTS*ADDR_W  per-port byte start address.
REQ-010 SHALL have port wdata  input  NUM_PORTS*32  per-port write word, little-endian.
REQ-011 SHALL have port len  input  NUM_PORTS*2  per-port size: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 4 bytes.
REQ-012 SHALL have port rdata  output  32  read word of the last completed read.
REQ-013 SHALL have port done  output  NUM_PORTS  one-cycle completion pulse, one-hot.
REQ-014 SHALL have port stall  output  NUM_PORTS  per-port stall request.
REQ-015 SHALL have port mem_a  output  ADDR_W  byte-memory address.
REQ-016 SHALL have port mem_dout  output  8  byte-memory write data.
REQ-017 SHALL have port mem_wr  output  1  byte-memory write strobe.
REQ-018 SHALL have port mem_din  input  8  byte-memory read data, valid one cycle after its address.

Function
REQ-019 SHALL implement states IDLE, ISSUE, LAST, DONE; only cycles with rdy=1 advance state, counters or pointers.
REQ-020 SHALL, in IDLE with any req high, grant one port g, latch its rw/addr/wdata/len (L = 1, 2 or 4), clear byte counter k, and enter ISSUE.
REQ-021 SHALL, for RR_MODE=1, search ports starting at rr_ptr upward modulo NUM_PORTS, and set rr_ptr = (g+1) mod NUM_PORTS on each grant.
REQ-022 SHALL, for RR_MODE=0, grant the lowest-indexed requesting port, leaving rr_ptr unused.
REQ-023 SHALL, in ISSUE, drive mem_a = start+k (mod 2^ADDR_W) and mem_wr = latched rw; for writes, mem_dout = wdata[8k+7:8k]; k increments each cycle.
REQ-024 SHALL leave ISSUE after k = L-1: writes go to DONE, reads go to LAST.
REQ-025 SHALL capture mem_din into rdata[8(k-1)+7:8(k-1)] during ISSUE cycles k >= 1, and capture the final byte L-1 in LAST.
REQ-026 SHALL zero rdata bytes L..3 on a read; sign extension is not performed here.
REQ-027 SHALL, in DONE, pulse done[g] for exactly one cycle, with rdata valid in that cycle; then enter IDLE.
REQ-028 SHALL hold rdata until the next read completion; writes SHALL NOT alter rdata.
REQ-029 SHALL drive mem_wr=0 in IDLE, LAST and DONE, and in any cycle with rdy=0; mem_a and mem_dout hold their last values there.
REQ-030 SHALL give latency, with req sampled in IDLE at cycle T: issue cycles T+1..T+L; done at T+L+1 for writes and T+L+2 for reads.
REQ-031 SHALL compute stall[i] = req[i] AND NOT done[i], combinationally.
REQ-032 SHALL sample req only in IDLE; a requester holds req and operands until done, then drops req or presents a new request in the next cycle.
REQ-033 SHALL complete an in-flight transfer even if req[g] drops mid-transfer.
REQ-034 SHALL spend at least one IDLE cycle between transfers.
REQ-035 SHALL, when rdy is low, hold all state; the memory holds mem_din stable while rdy is low, and capture resumes from the same k.
REQ-036 SHALL, for an address near the top of memory, wrap mem_a past 2^ADDR_W-1 to 0 within a transfer.

Reset
REQ-037 SHALL, on rst=1 at a rising clk edge (regardless of rdy or state): state=IDLE, k=0, rr_ptr=0, rdata=0, done=0, mem_a=0, mem_dout=0, mem_wr=0.
REQ-038 SHALL abandon any transfer in progress when reset is asserted, with no done pulse and no further mem_wr.

Verification
REQ-039 SHALL cover a write: port 0 write, len=10, addr=0x100, wdata=0x44332211 -> mem_a 0x100..0x103, mem_dout 11,22,33,44 with mem_wr=1 for 4 cycles, then done[0] at T+5.
REQ-040 SHALL cover a read: port 1 read, len=01, addr=0x20, memory bytes 0xAB, 0xCD -> rdata=0x0000CDAB with done[1] at T+4; stall[1]=1 until then.
REQ-041 SHALL cover round-robin: RR_MODE=1, both ports requesting continuously, 1-byte reads -> grants alternate 0,1,0,1; with RR_MODE=0 -> port 0 is always granted.
REQ-042 SHALL cover rdy gating: rdy=0 for 3 cycles mid 4-byte read -> mem_wr=0, k frozen, final rdata correct, done delayed exactly 3 cycles.
REQ-043 SHALL cover wrap: ADDR_W=32, write len=10 at 0xFFFFFFFE -> mem_a FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-044 SHALL cover reset mid-transfer: rst during ISSUE of a write -> next cycle IDLE, mem_wr=0, no done pulse, rr_ptr=0.
